// File: rtl/sigmoid_pipe_if.sv
// Handshake bundle for sigmoid_pipe: an input sample stream and a result stream.
// The design connects through the slave modport; the stream driver uses master.
interface sigmoid_pipe_if #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W_IN-1:0]  in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W_OUT-1:0] out_data;
  logic             out_sat;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/sigmoid_pipe.sv
// Three-stage PLAN sigmoid / clipped-ReLU activation with a valid/ready stream.
// The whole pipe advances together and freezes only when the output is held off.
module sigmoid_pipe #(
  parameter int W_IN    = 8,
  parameter int FRAC_IN = 4,
  parameter int W_OUT   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  sigmoid_pipe_if.slave bus
);
  localparam int F  = FRAC_IN + 5;
  localparam int AW = W_IN + 1;
  localparam int VW = AW + F + 2;
  localparam int PW = VW + W_OUT + 1;

  typedef logic [VW-1:0] v_t;
  typedef logic [PW-1:0] p_t;

  // Segment constants in F fraction bits; 2.375 is compared as 8|x| >= 19.
  localparam v_t C_ONE = v_t'(32) << FRAC_IN;
  localparam v_t C_27  = v_t'(27) << FRAC_IN;
  localparam v_t C_20  = v_t'(20) << FRAC_IN;
  localparam v_t C_16  = v_t'(16) << FRAC_IN;
  localparam v_t T_5   = v_t'(5)  << FRAC_IN;
  localparam v_t T_19  = v_t'(19) << FRAC_IN;
  localparam v_t T_1   = v_t'(1)  << FRAC_IN;
  localparam p_t P_ONE = p_t'(1);
  localparam p_t FULL  = P_ONE << W_OUT;
  localparam p_t MAXV  = FULL - P_ONE;

  logic             adv;
  logic [AW-1:0]    xe, ax_c;
  v_t               axv, v_c;
  p_t               pv, p, r, y_w;
  logic             sat_c;

  logic             s1_valid, s1_neg, s1_mode;
  logic [AW-1:0]    s1_ax;
  logic             s2_valid, s2_neg, s2_mode;
  logic [AW-1:0]    s2_ax;
  v_t               s2_v;
  logic             s3_valid, s3_sat;
  logic [W_OUT-1:0] s3_data;

  assign adv           = !(s3_valid && !bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = s3_valid;
  assign bus.out_data  = s3_data;
  assign bus.out_sat   = s3_sat;

  // One extra bit keeps |-2^(W_IN-1)| representable.
  assign xe   = {bus.in_data[W_IN-1], bus.in_data};
  assign ax_c = xe[AW-1] ? (~xe + AW'(1)) : xe;

  always_comb begin
    axv = v_t'(s1_ax);
    v_c = '0;
    if (axv >= T_5)
      v_c = C_ONE;
    else if ((axv << 3) >= T_19)
      v_c = axv + C_27;
    else if (axv >= T_1)
      v_c = (axv << 2) + C_20;
    else
      v_c = (axv << 3) + C_16;
  end

  always_comb begin
    pv    = (p_t'(s2_v) << W_OUT) + (P_ONE << (F - 1));
    p     = pv >> F;
    r     = (p_t'(s2_ax) << W_OUT) >> FRAC_IN;
    y_w   = '0;
    sat_c = 1'b0;
    if (!s2_mode) begin
      if (p >= FULL) begin
        y_w   = s2_neg ? '0 : MAXV;
        sat_c = 1'b1;
      end else begin
        y_w = s2_neg ? (FULL - p) : p;
      end
    end else if (s2_neg || (s2_ax == '0)) begin
      sat_c = s2_neg;
    end else if (r > MAXV) begin
      y_w   = MAXV;
      sat_c = 1'b1;
    end else begin
      y_w = r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_neg   <= 1'b0;
      s1_mode  <= 1'b0;
      s1_ax    <= '0;
      s2_valid <= 1'b0;
      s2_neg   <= 1'b0;
      s2_mode  <= 1'b0;
      s2_ax    <= '0;
      s2_v     <= '0;
      s3_valid <= 1'b0;
      s3_sat   <= 1'b0;
      s3_data  <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_neg   <= bus.in_data[W_IN-1];
      s1_mode  <= bus.in_mode;
      s1_ax    <= ax_c;
      s2_valid <= s1_valid;
      s2_neg   <= s1_neg;
      s2_mode  <= s1_mode;
      s2_ax    <= s1_ax;
      s2_v     <= v_c;
      s3_valid <= s2_valid;
      s3_sat   <= sat_c;
      s3_data  <= y_w[W_OUT-1:0];
    end
  end
endmodule

// File: doc/sigmoid_pipe.md
SIGMOID_PIPE -- requirements
Module: sigmoid_pipe

Interface
REQ-001 The block SHALL have parameter W_IN, default 8, meaning input width, signed two's complement.
REQ-002 The block SHALL have parameter FRAC_IN, default 4, meaning input fraction bits (default Q4.4, range -8.0..+7.9375).
REQ-003 The block SHALL have parameter W_OUT, default 8, meaning output width, unsigned, all fraction bits (Q0.W_OUT).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1, meaning the input sample is present.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts the sample this cycle.
REQ-008 The block SHALL have port in_data, input, W_IN, meaning the signed input x.
REQ-009 The block SHALL have port in_mode, input, 1, meaning per-sample mode: 0 = PLAN sigmoid, 1 = clipped ReLU.
REQ-010 The block SHALL have port out_valid, output, 1, meaning the result is present.
REQ-011 The block SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-012 The block SHALL have port out_data, output, W_OUT, meaning the result y.
REQ-013 The block SHALL have port out_sat, output, 1, meaning y was clamped to 2^W_OUT-1 or 0 by saturation.

Function
REQ-014 A transfer SHALL occur on a clock edge where valid and ready are both 1, on either side.
REQ-015 The datapath SHALL be a 3-stage pipeline: S1 sign/|x| at W_IN+1 bits; S2 segment select and slope/offset multiply-add; S3 mirror, round, saturate, register outputs.
REQ-016 Latency SHALL be exactly 3 cycles from input transfer to out_valid with no stall; throughput SHALL be 1 sample/cycle.
REQ-017 in_ready SHALL equal !(out_valid && !out_ready); when 0, all stages SHALL hold, and out_data/out_sat SHALL remain stable.
REQ-018 Bubbles (in_valid=0) SHALL propagate as invalid stages; an invalid stage SHALL be overwritten without stall.
REQ-019 Mode 0 on |x|, boundaries inclusive on the lower side: |x|>=5 -> 1.0; 2.375<=|x|<5 -> 0.03125|x|+0.84375; 1<=|x|<2.375 -> 0.125|x|+0.625; |x|<1 -> 0.25|x|+0.5.
REQ-020 Mode 0 intermediate arithmetic SHALL be exact (FRAC_IN+5 fraction bits); p = round-half-up to W_OUT fraction bits, range 0..2^W_OUT.
REQ-021 Mode 0 result SHALL be p for x>=0 and 2^W_OUT-p for x<0, then clamped to 2^W_OUT-1; out_sat=1 when clamped.
REQ-022 Mode 1: y=0 for x<=0 (out_sat=1 only if x<0); else x rescaled to W_OUT fraction bits (truncate), clamped to 2^W_OUT-1 with out_sat=1 when clamped.
REQ-023 -2^(W_IN-1) SHALL be handled without overflow (|x| uses W_IN+1 bits).
REQ-024 in_mode SHALL be captured with in_data and travel with the sample; mixed modes in flight SHALL be legal.

Reset
REQ-025 While rst_n=0: out_valid=0, out_data=0, out_sat=0, all stage valids=0, in_ready=1.
REQ-026 Reset mid-operation SHALL discard all in-flight samples; no output transfer SHALL follow from them after release.
REQ-027 The first edge after rst_n rises SHALL accept input normally.

Verification
REQ-028 Defaults, mode 0, out_ready=1: in_data 42 (2.625), 0, 16 (1.0), -42 -> out_data 237, 128, 192, 19 on cycles 3,4,5,6 after the first transfer, out_sat=0.
REQ-029 Mode 0 extremes: in_data 127 -> 255 out_sat=1; in_data -128 -> 0 out_sat=1; in_data 80 (5.0) -> 255 out_sat=1.
REQ-030 Mode 1: in_data 4 -> 64 sat 0; 42 -> 255 sat 1; -5 -> 0 sat 1; 0 -> 0 sat 0; interleaved with mode 0 sample 42 -> 237.
REQ-031 Back-pressure: stream 6 samples, out_ready=0 for 4 cycles mid-stream -> in_ready=0 while out_valid&&!out_ready, out_data stable, all 6 results delivered in order, none lost or duplicated.
REQ-032 Reset with 3 samples in flight -> out_valid=0 immediately (asynchronous), no stale output after release; next input 0 -> 128 after 3 cycles.
